// File: rtl/ssd1306_spi_rx.sv
// ssd1306_spi_rx
//   Receive-side model of the SSD1306 4-wire SPI interface. The SPI pins are
//   oversampled in the clk_in domain and assembled into bytes. Command bytes
//   update a shadow register set. Data bytes produce frame-buffer writes.
//
//   Optional feature macro: SSD1306_RX_HADDR_EN
//     defined   : the argument of opcode 0x20 selects the addressing mode
//                 (0 = horizontal, 1/2 = page; reset mode is 2)
//     undefined : the 0x20 argument is consumed and ignored (page mode only)
//
//   Ports
//     clk_in, reset_in  : system clock, asynchronous active-high reset
//     oled_csn          : chip select, active low
//     oled_dc           : 1 = data, 0 = command
//     oled_clk          : SPI clock, mode 0
//     oled_mosi         : serial data, MSB first
//     fb_we/addr/data   : one-cycle frame-buffer write (addr = page*COLUMNS+col)
//     cmd_valid         : one-cycle pulse per command-phase byte
//     cmd_code          : the command/argument byte
//     cmd_arg           : qualifies cmd_valid, byte was consumed as an argument
//     start_line        : display start line
//     display_offset    : display offset
//     contrast          : contrast setting (resets to 8'h7F)
//     o_dbg_state       : FSM state, 0 = S_CMD, 1 = S_ARG
//
//   Handshake: fb_we and cmd_valid are single-cycle strobes with no
//   back-pressure; their companion outputs are valid only in the strobe cycle
//   and hold their last value otherwise.
module ssd1306_spi_rx #(
    parameter int COLUMNS = 128,
    parameter int PAGES   = 8,
    parameter int ADDR_W  = 10
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              oled_csn,
    input  logic              oled_dc,
    input  logic              oled_clk,
    input  logic              oled_mosi,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [7:0]        fb_data,
    output logic              cmd_valid,
    output logic [7:0]        cmd_code,
    output logic              cmd_arg,
    output logic [5:0]        start_line,
    output logic [5:0]        display_offset,
    output logic [7:0]        contrast,
    output logic              o_dbg_state
);

    typedef enum logic {S_CMD = 1'b0, S_ARG = 1'b1} state_t;

    // Two-flop synchronisers; the clock gets a third flop for edge detection.
    logic [1:0] r_csn_s;
    logic [2:0] r_sck_s;
    logic [1:0] r_mosi_s;
    logic [1:0] r_dc_s;

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_csn_s  <= 2'b11;
            r_sck_s  <= 3'b000;
            r_mosi_s <= 2'b00;
            r_dc_s   <= 2'b00;
        end else begin
            r_csn_s  <= {r_csn_s[0], oled_csn};
            r_sck_s  <= {r_sck_s[1:0], oled_clk};
            r_mosi_s <= {r_mosi_s[0], oled_mosi};
            r_dc_s   <= {r_dc_s[0], oled_dc};
        end
    end

    logic       w_csn;
    logic       w_sck_rise;
    logic       w_mosi;
    logic       w_dc;
    logic [7:0] w_byte;
    logic       w_done;

    state_t      r_state;
    logic [7:0]  r_op;
    logic [6:0]  r_shreg;
    logic [2:0]  r_bitcnt;
    logic [6:0]  r_col;
    logic [2:0]  r_page;
`ifdef SSD1306_RX_HADDR_EN
    logic [1:0]  r_mode;
`endif

    assign w_csn      = r_csn_s[1];
    assign w_sck_rise = r_sck_s[1] & ~r_sck_s[2] & ~w_csn;
    assign w_mosi     = r_mosi_s[1];
    assign w_dc       = r_dc_s[1];
    // The completed byte includes the bit arriving on this edge.
    assign w_byte     = {r_shreg, w_mosi};
    assign w_done     = w_sck_rise && (r_bitcnt == 3'd7);

    assign o_dbg_state = (r_state == S_ARG);

    function automatic logic takes_arg(input logic [7:0] op);
        case (op)
            8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3,
            8'hD5, 8'hD9, 8'hDA, 8'hDB: takes_arg = 1'b1;
            default:                    takes_arg = 1'b0;
        endcase
    endfunction

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state        <= S_CMD;
            r_op           <= 8'h00;
            r_shreg        <= 7'd0;
            r_bitcnt       <= 3'd0;
            r_col          <= 7'd0;
            r_page         <= 3'd0;
`ifdef SSD1306_RX_HADDR_EN
            r_mode         <= 2'd2;
`endif
            fb_we          <= 1'b0;
            fb_addr        <= '0;
            fb_data        <= 8'h00;
            cmd_valid      <= 1'b0;
            cmd_code       <= 8'h00;
            cmd_arg        <= 1'b0;
            start_line     <= 6'd0;
            display_offset <= 6'd0;
            contrast       <= 8'h7F;
        end else begin
            fb_we     <= 1'b0;
            cmd_valid <= 1'b0;

            if (w_csn) begin
                // Partial byte is discarded; FSM and pointers are kept.
                r_bitcnt <= 3'd0;
            end else if (w_sck_rise) begin
                r_shreg  <= w_byte[6:0];
                r_bitcnt <= r_bitcnt + 3'd1;
            end

            if (w_done) begin
                if (w_dc) begin
                    fb_we   <= 1'b1;
                    fb_addr <= ADDR_W'(r_page) * ADDR_W'(COLUMNS) + ADDR_W'(r_col);
                    fb_data <= w_byte;
                    if (r_col == 7'(COLUMNS - 1)) begin
                        r_col <= 7'd0;
`ifdef SSD1306_RX_HADDR_EN
                        if (r_mode == 2'd0)
                            r_page <= (r_page == 3'(PAGES - 1)) ? 3'd0 : r_page + 3'd1;
`endif
                    end else begin
                        r_col <= r_col + 7'd1;
                    end
                    // A data byte aborts any pending argument.
                    r_state <= S_CMD;
                end else begin
                    cmd_valid <= 1'b1;
                    cmd_code  <= w_byte;
                    if (r_state == S_CMD) begin
                        cmd_arg <= 1'b0;
                        if (w_byte[7:4] == 4'h0) begin
                            r_col[3:0] <= w_byte[3:0];
                        end else if (w_byte[7:4] == 4'h1) begin
                            r_col[6:4] <= w_byte[2:0];
                        end else if (w_byte[7:6] == 2'b01) begin
                            start_line <= w_byte[5:0];
                        end else if (w_byte[7:3] == 5'b10110) begin
                            if ({1'b0, w_byte[2:0]} >= 4'(PAGES))
                                r_page <= 3'(PAGES - 1);
                            else
                                r_page <= w_byte[2:0];
                        end else if (takes_arg(w_byte)) begin
                            r_op    <= w_byte;
                            r_state <= S_ARG;
                        end
                    end else begin
                        cmd_arg <= 1'b1;
                        case (r_op)
                            8'hD3:   display_offset <= w_byte[5:0];
                            8'h81:   contrast       <= w_byte;
`ifdef SSD1306_RX_HADDR_EN
                            8'h20:   r_mode         <= w_byte[1:0];
`endif
                            default: ;
                        endcase
                        r_state <= S_CMD;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ssd1306_spi_rx.sv
// Testbench for ssd1306_spi_rx: directed scenarios followed by random traffic.
// A reference model computes every expected strobe at the time a byte is
// issued and pushes it into exp_q; an independent monitor pops and compares
// whenever fb_we or cmd_valid is seen.
module tb_ssd1306_spi_rx;

  localparam int COLUMNS = 128;
  localparam int PAGES   = 8;
  localparam int ADDR_W  = 10;
  localparam int W       = 20;  // {is_data, arg, addr[9:0], byte[7:0]}

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_in;
  logic              oled_csn, oled_dc, oled_clk, oled_mosi;
  logic              fb_we;
  logic [ADDR_W-1:0] fb_addr;
  logic [7:0]        fb_data;
  logic              cmd_valid;
  logic [7:0]        cmd_code;
  logic              cmd_arg;
  logic [5:0]        start_line, display_offset;
  logic [7:0]        contrast;
  logic              dbg_state;

  ssd1306_spi_rx #(.COLUMNS(COLUMNS), .PAGES(PAGES), .ADDR_W(ADDR_W)) dut (
    .clk_in         (clk),
    .reset_in       (reset_in),
    .oled_csn       (oled_csn),
    .oled_dc        (oled_dc),
    .oled_clk       (oled_clk),
    .oled_mosi      (oled_mosi),
    .fb_we          (fb_we),
    .fb_addr        (fb_addr),
    .fb_data        (fb_data),
    .cmd_valid      (cmd_valid),
    .cmd_code       (cmd_code),
    .cmd_arg        (cmd_arg),
    .start_line     (start_line),
    .display_offset (display_offset),
    .contrast       (contrast),
    .o_dbg_state    (dbg_state)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_col, m_page, m_op, m_start, m_off, m_contrast, m_mode;

  task automatic model_reset();
    m_col = 0; m_page = 0; m_op = -1;
    m_start = 0; m_off = 0; m_contrast = 'h7F; m_mode = 2;
  endtask

  task automatic model_byte(input logic [7:0] b, input logic dc);
    int addr;
    if (dc) begin
      addr = (m_page * COLUMNS + m_col) % (1 << ADDR_W);
      exp_q.push_back({1'b1, 1'b0, 10'(addr), b});
      if (m_col == COLUMNS - 1) begin
        m_col = 0;
`ifdef SSD1306_RX_HADDR_EN
        if (m_mode == 0) m_page = (m_page == PAGES - 1) ? 0 : m_page + 1;
`endif
      end else begin
        m_col = m_col + 1;
      end
      m_op = -1;
    end else if (m_op < 0) begin
      exp_q.push_back({1'b0, 1'b0, 10'd0, b});
      if (b <= 8'h0F)                    m_col = (m_col & 'h70) | int'(b[3:0]);
      else if (b <= 8'h1F)               m_col = (m_col & 'h0F) | (int'(b[2:0]) << 4);
      else if (b >= 8'h40 && b <= 8'h7F) m_start = int'(b[5:0]);
      else if (b >= 8'hB0 && b <= 8'hB7) m_page = (int'(b) - 'hB0 >= PAGES) ? PAGES - 1 : int'(b) - 'hB0;
      else if (b inside {8'h20, 8'h81, 8'h8D, 8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB})
        m_op = int'(b);
    end else begin
      exp_q.push_back({1'b0, 1'b1, 10'd0, b});
      if (m_op == 'hD3)      m_off = int'(b[5:0]);
      else if (m_op == 'h81) m_contrast = int'(b);
`ifdef SSD1306_RX_HADDR_EN
      else if (m_op == 'h20) m_mode = int'(b[1:0]);
`endif
      m_op = -1;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [W-1:0] act;
    logic [W-1:0] e;
    if (reset_in === 1'b0 && (fb_we === 1'b1 || cmd_valid === 1'b1)) begin
      if (fb_we === 1'b1 && cmd_valid === 1'b1) begin
        n_tests++; n_fail++;
        $display("FAIL strobe_overlap: got fb_we=1 cmd_valid=1 expected one strobe");
      end
      act = (fb_we === 1'b1) ? {1'b1, 1'b0, fb_addr, fb_data}
                             : {1'b0, cmd_arg, 10'd0, cmd_code};
      if (exp_q.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_strobe: got %0h expected none", act);
      end else begin
        e = exp_q.pop_front();
        check("strobe{data,arg,addr,byte}", 32'(act), 32'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] b, input int nbits, input logic dc);
    oled_csn = 1'b0;
    oled_dc  = dc;
    for (int i = 0; i < nbits; i++) begin
      oled_mosi = b[7 - i];
      wait_clk($urandom_range(3, 5));
      oled_clk = 1'b1;
      wait_clk($urandom_range(3, 5));
      oled_clk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic dc);
    model_byte(b, dc);
    spi_bits(b, 8, dc);
    wait_clk(4);
  endtask

  task automatic cs_toggle();
    oled_csn = 1'b1;
    wait_clk($urandom_range(3, 6));
    oled_csn = 1'b0;
    wait_clk(2);
  endtask

  task automatic do_reset();
    reset_in = 1'b1;
    wait_clk(3);
    model_reset();
    exp_q.delete();
    reset_in = 1'b0;
    wait_clk(2);
  endtask

  task automatic check_reset_outputs();
    check("rst_fb_we", 32'(fb_we), 0);
    check("rst_fb_addr", 32'(fb_addr), 0);
    check("rst_fb_data", 32'(fb_data), 0);
    check("rst_cmd_valid", 32'(cmd_valid), 0);
    check("rst_cmd_code", 32'(cmd_code), 0);
    check("rst_cmd_arg", 32'(cmd_arg), 0);
    check("rst_start_line", 32'(start_line), 0);
    check("rst_display_offset", 32'(display_offset), 0);
    check("rst_contrast", 32'(contrast), 32'h7F);
    check("rst_state", 32'(dbg_state), 0);
  endtask

  task automatic check_regs();
    check("start_line", 32'(start_line), 32'(m_start));
    check("display_offset", 32'(display_offset), 32'(m_off));
    check("contrast", 32'(contrast), 32'(m_contrast));
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < budget) begin
      wait_clk(1);
      k++;
    end
    if (exp_q.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset_in  = 1'b1;
    oled_csn  = 1'b1;
    oled_dc   = 1'b0;
    oled_clk  = 1'b0;
    oled_mosi = 1'b0;
    model_reset();
    do_reset();
    check_reset_outputs();

    // Two data bytes at column 0 and 1.
    send_byte(8'hA5, 1'b1);
    send_byte(8'h3C, 1'b1);

    // Page 3, column 0x25 -> address 421.
    send_byte(8'hB3, 1'b0);
    send_byte(8'h05, 1'b0);
    send_byte(8'h12, 1'b0);
    send_byte(8'hFF, 1'b1);

    // Offset argument across a CS toggle, contrast, start line.
    send_byte(8'hD3, 1'b0);
    cs_toggle();
    send_byte(8'h11, 1'b0);
    send_byte(8'h81, 1'b0);
    send_byte(8'h20, 1'b0);
    send_byte(8'h47, 1'b0);
    drain(50);
    check("offset_0x11", 32'(display_offset), 32'h11);
    check("contrast_0x20", 32'(contrast), 32'h20);
    check("start_line_7", 32'(start_line), 32'h07);

    // Column wrap at the last column of page 2.
`ifdef SSD1306_RX_HADDR_EN
    send_byte(8'h20, 1'b0);
    send_byte(8'h00, 1'b0);
`endif
    send_byte(8'hB2, 1'b0);
    send_byte(8'h0F, 1'b0);
    send_byte(8'h17, 1'b0);
    send_byte(8'h5A, 1'b1);
    send_byte(8'hC3, 1'b1);

    // Partial byte is discarded on CS high; next full byte is an opcode.
    spi_bits(8'hE7, 5, 1'b1);
    cs_toggle();
    send_byte(8'h81, 1'b0);
    send_byte(8'h33, 1'b0);
    drain(50);
    check("contrast_0x33", 32'(contrast), 32'h33);

    // Reset while an argument is pending.
    send_byte(8'hD3, 1'b0);
    drain(50);
    do_reset();
    check_reset_outputs();
    send_byte(8'h11, 1'b0);
    drain(50);
    check("offset_kept_0", 32'(display_offset), 0);

    // Reset in the middle of a byte, then a clean byte.
    spi_bits(8'hF0, 4, 1'b1);
    do_reset();
    check_reset_outputs();
    oled_csn = 1'b1;
    wait_clk(4);
    send_byte(8'h66, 1'b1);

    // Random traffic.
    for (int n = 0; n < 250; n++) begin
      logic [7:0] b;
      logic       dc;
      b  = 8'($urandom_range(0, 255));
      dc = ($urandom_range(0, 99) < 40);
      if ($urandom_range(0, 99) < 5) begin
        spi_bits(8'($urandom), $urandom_range(1, 7), 1'($urandom));
        cs_toggle();
      end
      send_byte(b, dc);
      if ($urandom_range(0, 99) < 15) cs_toggle();
    end
    drain(200);
    check_regs();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL global_timeout: got no finish expected finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
